// File: rtl/tta16_mem_arbiter_pkg.sv
// Shared encodings for the tta16 external-memory arbiter: FSM states and
// Wishbone cycle-type identifiers.
package tta16_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_GNT0 = 2'b01,
        ARB_GNT1 = 2'b10
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/tta16_mem_arbiter_watchdog.sv
// Bus-cycle watchdog: counts strobed cycles that receive no termination and
// emits a one-cycle fire pulse when the count reaches TIMEOUT (0 disables).
module tta16_wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic term,
    input  logic restart,
    output logic fire
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] cnt_q, cnt_d;

    // A genuine slave termination in the same cycle wins over the timeout.
    assign fire = (LIMIT != 8'd0) && active && !term && (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (restart || term || fire) begin
            cnt_d = 8'd0;
        end else if (active) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tta16_mem_arbiter.sv
// Two-master round-robin Wishbone arbiter for the tta16 external memory bus;
// the grant is held for a whole bus cycle so bursts are never split.
module tta16_mem_arbiter
    import tta16_mem_arbiter_pkg::*;
#(
    parameter int ADDRESS = 21,
    parameter int TIMEOUT = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               m0_cyc_i,
    input  logic               m0_stb_i,
    input  logic               m0_we_i,
    input  logic [2:0]         m0_cti_i,
    input  logic [1:0]         m0_bte_i,
    input  logic [ADDRESS-1:0] m0_adr_i,
    input  logic [3:0]         m0_sel_i,
    input  logic [31:0]        m0_dat_i,
    output logic               m0_ack_o,
    output logic               m0_rty_o,
    output logic               m0_err_o,
    output logic [3:0]         m0_sel_o,
    output logic [31:0]        m0_dat_o,
    input  logic               m1_cyc_i,
    input  logic               m1_stb_i,
    input  logic               m1_we_i,
    input  logic [2:0]         m1_cti_i,
    input  logic [1:0]         m1_bte_i,
    input  logic [ADDRESS-1:0] m1_adr_i,
    input  logic [3:0]         m1_sel_i,
    input  logic [31:0]        m1_dat_i,
    output logic               m1_ack_o,
    output logic               m1_rty_o,
    output logic               m1_err_o,
    output logic [3:0]         m1_sel_o,
    output logic [31:0]        m1_dat_o,
    output logic               s_cyc_o,
    output logic               s_stb_o,
    output logic               s_we_o,
    output logic [2:0]         s_cti_o,
    output logic [1:0]         s_bte_o,
    output logic [ADDRESS-1:0] s_adr_o,
    output logic [3:0]         s_sel_o,
    output logic [31:0]        s_dat_o,
    input  logic               s_ack_i,
    input  logic               s_rty_i,
    input  logic               s_err_i,
    input  logic [3:0]         s_sel_i,
    input  logic [31:0]        s_dat_i
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       s_stb_raw;
    logic       wd_fire;
    logic       gnt0, gnt1;

    // last_q names the most recently granted master; a tie goes to the other.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? ARB_GNT0 : ARB_GNT1;
                end else if (m0_cyc_i) begin
                    state_d = ARB_GNT0;
                end else if (m1_cyc_i) begin
                    state_d = ARB_GNT1;
                end
            end
            ARB_GNT0: if (!m0_cyc_i) state_d = m1_cyc_i ? ARB_GNT1 : ARB_IDLE;
            ARB_GNT1: if (!m1_cyc_i) state_d = m0_cyc_i ? ARB_GNT0 : ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
        if (state_d != state_q) begin
            if (state_d == ARB_GNT0) begin
                last_d = 1'b0;
            end else if (state_d == ARB_GNT1) begin
                last_d = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ARB_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Slave-side mux is driven purely by the registered state, so two masters
    // can never overlap on the bus.
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_raw = 1'b0;
        s_we_o    = 1'b0;
        s_cti_o   = CTI_CLASSIC;
        s_bte_o   = 2'b00;
        s_adr_o   = '0;
        s_sel_o   = 4'b0000;
        s_dat_o   = 32'd0;
        case (state_q)
            ARB_GNT0: begin
                s_cyc_o   = m0_cyc_i;
                s_stb_raw = m0_stb_i;
                s_we_o    = m0_we_i;
                s_cti_o   = m0_cti_i;
                s_bte_o   = m0_bte_i;
                s_adr_o   = m0_adr_i;
                s_sel_o   = m0_sel_i;
                s_dat_o   = m0_dat_i;
            end
            ARB_GNT1: begin
                s_cyc_o   = m1_cyc_i;
                s_stb_raw = m1_stb_i;
                s_we_o    = m1_we_i;
                s_cti_o   = m1_cti_i;
                s_bte_o   = m1_bte_i;
                s_adr_o   = m1_adr_i;
                s_sel_o   = m1_sel_i;
                s_dat_o   = m1_dat_i;
            end
            default: ;
        endcase
    end

    tta16_wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .active  (s_cyc_o & s_stb_raw),
        .term    (s_ack_i | s_rty_i | s_err_i),
        .restart (state_d != state_q),
        .fire    (wd_fire)
    );

    // The strobe is withdrawn in the cycle the watchdog terminates the master.
    assign s_stb_o = s_stb_raw & ~wd_fire;

    assign gnt0 = (state_q == ARB_GNT0);
    assign gnt1 = (state_q == ARB_GNT1);

    assign m0_ack_o = gnt0 & s_ack_i;
    assign m0_rty_o = gnt0 & s_rty_i;
    assign m0_err_o = gnt0 & (s_err_i | wd_fire);
    assign m1_ack_o = gnt1 & s_ack_i;
    assign m1_rty_o = gnt1 & s_rty_i;
    assign m1_err_o = gnt1 & (s_err_i | wd_fire);

    assign m0_sel_o = s_sel_i;
    assign m0_dat_o = s_dat_i;
    assign m1_sel_o = s_sel_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_tta16_mem_arbiter.sv
// Self-checking bench for tta16_mem_arbiter: behavioural slave, per-master
// scoreboards of expected terminations, and targeted timing checks.
`timescale 1ns/1ps
module tb_tta16_mem_arbiter;
    import tta16_mem_arbiter_pkg::*;

    localparam int AW = 21;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              mcyc [2];
    logic              mstb [2];
    logic              mwe  [2];
    logic [2:0]        mcti [2];
    logic [1:0]        mbte [2];
    logic [AW-1:0]     madr [2];
    logic [3:0]        msel [2];
    logic [31:0]       mdat [2];
    logic [1:0]        mack, mrty, merr;
    logic [3:0]        m0_sel, m1_sel;
    logic [31:0]       m0_dat, m1_dat;

    logic              s_cyc, s_stb, s_we;
    logic [2:0]        s_cti;
    logic [1:0]        s_bte;
    logic [AW-1:0]     s_adr;
    logic [3:0]        s_sel;
    logic [31:0]       s_dat;
    logic              s_ack = 1'b0, s_rty = 1'b0, s_err = 1'b0;
    logic [3:0]        s_sel_i = 4'hF;
    logic [31:0]       s_dat_i = 32'd0;

    tta16_mem_arbiter #(.ADDRESS(AW), .TIMEOUT(8)) dut (
        .wb_clk_i (clk),      .wb_rst_i (rst),
        .m0_cyc_i (mcyc[0]),  .m0_stb_i (mstb[0]),  .m0_we_i  (mwe[0]),
        .m0_cti_i (mcti[0]),  .m0_bte_i (mbte[0]),  .m0_adr_i (madr[0]),
        .m0_sel_i (msel[0]),  .m0_dat_i (mdat[0]),
        .m0_ack_o (mack[0]),  .m0_rty_o (mrty[0]),  .m0_err_o (merr[0]),
        .m0_sel_o (m0_sel),   .m0_dat_o (m0_dat),
        .m1_cyc_i (mcyc[1]),  .m1_stb_i (mstb[1]),  .m1_we_i  (mwe[1]),
        .m1_cti_i (mcti[1]),  .m1_bte_i (mbte[1]),  .m1_adr_i (madr[1]),
        .m1_sel_i (msel[1]),  .m1_dat_i (mdat[1]),
        .m1_ack_o (mack[1]),  .m1_rty_o (mrty[1]),  .m1_err_o (merr[1]),
        .m1_sel_o (m1_sel),   .m1_dat_o (m1_dat),
        .s_cyc_o  (s_cyc),    .s_stb_o  (s_stb),    .s_we_o   (s_we),
        .s_cti_o  (s_cti),    .s_bte_o  (s_bte),    .s_adr_o  (s_adr),
        .s_sel_o  (s_sel),    .s_dat_o  (s_dat),
        .s_ack_i  (s_ack),    .s_rty_i  (s_rty),    .s_err_i  (s_err),
        .s_sel_i  (s_sel_i),  .s_dat_i  (s_dat_i)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Slave model: responds slave_wait cycles after seeing a strobe.
    // slave_mode 0 = ack, 1 = retry, 2 = never respond.
    int slave_wait = 0;
    int slave_mode = 0;
    int wcnt = 0;

    function automatic logic [31:0] sdata(input logic [AW-1:0] a);
        if (a == 21'h00010) return 32'hDEADBEEF;
        return {11'd0, a} ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) begin
        s_ack <= 1'b0;
        s_rty <= 1'b0;
        if (s_cyc && s_stb && !(s_ack || s_rty)) begin
            if (slave_mode != 2 && wcnt >= slave_wait) begin
                wcnt    <= 0;
                s_ack   <= (slave_mode == 0);
                s_rty   <= (slave_mode == 1);
                s_dat_i <= sdata(s_adr);
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    // Scoreboard entries: {kind, data}; kind 1 = ack, 2 = retry, 3 = error.
    logic [33:0] q0 [$];
    logic [33:0] q1 [$];
    logic        burst_watch = 1'b0;

    task automatic mon_master(input int m, input logic ack, input logic rty,
                              input logic err, input logic [31:0] dat);
        logic [1:0]  k;
        logic [33:0] e;
        int          depth;
        k = ack ? 2'd1 : (rty ? 2'd2 : (err ? 2'd3 : 2'd0));
        if (k == 2'd0) return;
        depth = (m == 0) ? q0.size() : q1.size();
        if (depth == 0) begin
            check($sformatf("m%0d_unexpected_term", m), 32'(k), 32'd0);
            return;
        end
        if (m == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("m%0d_term_kind", m), 32'(k), 32'(e[33:32]));
        if (e[33:32] != 2'd3) check($sformatf("m%0d_rdata", m), dat, e[31:0]);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon_master(0, mack[0], mrty[0], merr[0], m0_dat);
            mon_master(1, mack[1], mrty[1], merr[1], m1_dat);
            if (burst_watch && mcyc[0] && s_cyc)
                check("burst_m1_adr_leak", 32'(s_adr == madr[1]), 32'd0);
        end
    end

    task automatic run_master(input int m, input logic [AW-1:0] adr, input logic we,
                              input int beats, input logic [1:0] kind);
        int b;
        int guard;
        for (int i = 0; i < beats; i++) begin
            if (m == 0) q0.push_back({kind, sdata(adr + AW'(i))});
            else        q1.push_back({kind, sdata(adr + AW'(i))});
        end
        @(posedge clk); #1;
        mcyc[m] = 1'b1; mstb[m] = 1'b1; mwe[m] = we; madr[m] = adr;
        msel[m] = 4'hF; mdat[m] = 32'hC0DE_0000 | 32'(adr);
        mcti[m] = (beats > 1) ? CTI_INCR : CTI_CLASSIC;
        b = 0;
        guard = 0;
        while (b < beats) begin
            @(negedge clk);
            if (mack[m] || mrty[m] || merr[m]) begin
                b++;
                @(posedge clk); #1;
                if (b < beats) begin
                    madr[m] = adr + AW'(b);
                    mcti[m] = (b == beats - 1) ? CTI_EOB : CTI_INCR;
                end
            end else if (++guard > 60) begin
                check($sformatf("m%0d_bus_timeout", m), 32'd0, 32'd1);
                break;
            end
        end
        mcyc[m] = 1'b0; mstb[m] = 1'b0; mwe[m] = 1'b0; mcti[m] = CTI_CLASSIC;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_cyc", 32'(s_cyc), 32'd0);
        check("rst_s_stb", 32'(s_stb), 32'd0);
        check("rst_s_adr", 32'(s_adr), 32'd0);
        check("rst_terms", 32'({mack, mrty, merr}), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic exp_last;
        int   first;
        int   seen;
        for (int m = 0; m < 2; m++) begin
            mcyc[m] = 1'b0; mstb[m] = 1'b0; mwe[m] = 1'b0; mcti[m] = CTI_CLASSIC;
            mbte[m] = 2'b00; madr[m] = '0; msel[m] = 4'h0; mdat[m] = 32'd0;
        end
        do_reset();

        // Single read by master 0 with a two-cycle slave.
        slave_wait = 2;
        fork
            run_master(0, 21'h00010, 1'b0, 1, 2'd1);
            begin
                @(posedge clk); @(negedge clk);
                check("gnt_latency_before", 32'(s_cyc), 32'd0);
                @(posedge clk); @(negedge clk);
                check("gnt_latency_after", 32'(s_cyc), 32'd1);
                check("gnt_adr", 32'(s_adr), 32'h10);
            end
        join
        slave_wait = 0;

        // Round-robin on simultaneous requests, with solo cycles moving 'last'.
        do_reset();
        exp_last = 1'b1;
        for (int r = 0; r < 4; r++) begin
            if (r == 1) begin run_master(0, 21'h00250, 1'b0, 1, 2'd1); exp_last = 1'b0; end
            if (r == 3) begin run_master(1, 21'h00350, 1'b1, 1, 2'd1); exp_last = 1'b1; end
            first = exp_last ? 0 : 1;
            fork
                run_master(0, AW'(32'h200 + r), 1'b0, 1, 2'd1);
                run_master(1, AW'(32'h300 + r), 1'b0, 1, 2'd1);
                begin
                    @(posedge clk); @(posedge clk); @(negedge clk);
                    check($sformatf("rr_first_r%0d", r), 32'(s_adr),
                          (first == 0) ? 32'h200 + r : 32'h300 + r);
                end
            join
            exp_last = (first == 0) ? 1'b1 : 1'b0;
        end

        // Master 0 burst while master 1 requests throughout.
        fork
            run_master(0, 21'h00100, 1'b0, 4, 2'd1);
            begin @(posedge clk); run_master(1, 21'h1FFFF, 1'b0, 1, 2'd1); end
            begin
                @(posedge clk); @(posedge clk); #2;
                burst_watch = 1'b1;
                for (int i = 0; i < 60 && mcyc[0]; i++) @(negedge clk);
                burst_watch = 1'b0;
                @(posedge clk); @(negedge clk);
                check("handover_cyc", 32'(s_cyc), 32'd1);
                check("handover_adr", 32'(s_adr), 32'h1FFFF);
            end
        join

        // Slave never answers: watchdog error after 8 strobed cycles.
        slave_mode = 2;
        fork
            run_master(0, 21'h00700, 1'b0, 1, 2'd3);
            begin @(posedge clk); @(posedge clk); run_master(1, 21'h007FF, 1'b0, 1, 2'd1); end
            begin
                @(posedge clk); @(posedge clk);
                seen = 0;
                repeat (8) begin
                    @(negedge clk);
                    seen = seen + int'(merr[0]);
                    @(posedge clk);
                end
                check("wd_no_early_err", 32'(seen), 32'd0);
                @(negedge clk);
                check("wd_err_pulse", 32'(merr[0]), 32'd1);
                check("wd_stb_forced_low", 32'(s_stb), 32'd0);
                check("wd_m1_no_err", 32'(merr[1]), 32'd0);
                slave_mode = 0;
                @(posedge clk); @(negedge clk);
                check("wd_err_single", 32'(merr[0]), 32'd0);
                @(posedge clk); @(negedge clk);
                check("wd_then_m1_adr", 32'(s_adr), 32'h7FF);
            end
        join

        // Asynchronous reset in the middle of a master 1 burst.
        slave_mode = 2;
        @(posedge clk); #1;
        mcyc[1] = 1'b1; mstb[1] = 1'b1; madr[1] = 21'h00400; mcti[1] = CTI_INCR;
        @(posedge clk); #1;
        mcyc[0] = 1'b1; mstb[0] = 1'b1; madr[0] = 21'h00500; mcti[0] = CTI_CLASSIC;
        @(posedge clk); @(posedge clk); #3;
        check("pre_rst_owner", 32'(s_adr), 32'h400);
        rst = 1'b1;
        #1;
        check("async_rst_cyc", 32'(s_cyc), 32'd0);
        check("async_rst_stb", 32'(s_stb), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check("post_rst_m0_first", 32'(s_adr), 32'h500);
        @(posedge clk); #1;
        mcyc[0] = 1'b0; mstb[0] = 1'b0; mcyc[1] = 1'b0; mstb[1] = 1'b0;
        repeat (2) @(posedge clk);
        slave_mode = 0;

        // Retry on a master 1 write is passed through without losing the grant.
        slave_mode = 1;
        fork
            run_master(1, 21'h00600, 1'b1, 1, 2'd2);
            begin
                seen = 0;
                for (int i = 0; i < 40 && seen == 0; i++) begin
                    @(negedge clk);
                    if (mrty[1]) seen = 1;
                end
                check("rty_seen", 32'(seen), 32'd1);
                check("rty_grant_kept", 32'(s_cyc), 32'd1);
                check("rty_adr", 32'(s_adr), 32'h600);
                check("rty_m0_quiet", 32'({mack[0], mrty[0], merr[0]}), 32'd0);
            end
        join
        slave_mode = 0;

        repeat (3) @(posedge clk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
